// File: rtl/mult_arb_ctrl.sv
// Two-requester round-robin front end for a WIDTH-cycle shift-and-add multiplier.
// Optional build macro MULT_EARLY_TERM_EN ends CALC as soon as the remaining multiplier bits are zero.
module mult_arb_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_z,
    output logic                 res_id,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2*WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                id_q, id_d;
    logic                ptr_q, ptr_d;
    logic                grant0_s, grant1_s;
    logic                last_s;

    // Arbitration: a lone requester always wins, the pointer breaks ties.
    always_comb begin
        grant0_s = req0_valid & (~req1_valid | ~ptr_q);
        grant1_s = req1_valid & (~req0_valid |  ptr_q);
        if (reset && (state_q == IDLE)) begin
            req0_ready = grant0_s;
            req1_ready = grant1_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Final CALC iteration detection; the early exit fires once no set bits of b remain.
    always_comb begin
        last_s = (cnt_q == CW'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
        if (b_q[WIDTH-1:1] == {(WIDTH-1){1'b0}}) begin
            last_s = 1'b1;
        end else begin
            last_s = (cnt_q == CW'(WIDTH - 1));
        end
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (grant0_s) begin
                    a_d     = {{WIDTH{1'b0}}, req0_a};
                    b_d     = req0_b;
                    id_d    = 1'b0;
                    acc_d   = {(2*WIDTH){1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = CALC;
                end else if (grant1_s) begin
                    a_d     = {{WIDTH{1'b0}}, req1_a};
                    b_d     = req1_b;
                    id_d    = 1'b1;
                    acc_d   = {(2*WIDTH){1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end else begin
                    acc_d = acc_q;
                end
                a_d   = {a_q[2*WIDTH-2:0], 1'b0};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                    ptr_d   = ~id_q;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= {(2*WIDTH){1'b0}};
            b_q     <= {WIDTH{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
            cnt_q   <= {CW{1'b0}};
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_z     = acc_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_mult_arb_ctrl.sv
// Self-checking bench for mult_arb_ctrl: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model (products and cycle counts).
module tb_mult_arb_ctrl;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_ready;
    logic [31:0] res_z;
    logic        res_id;
    logic        busy;

    int n_checks;
    int n_pass;

    mult_arb_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_id(res_id),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] z;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [15:0] b);
        int l;
        l = 16;
`ifdef MULT_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) l = i + 1;
        end
`endif
        return l;
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'($urandom_range(0, 255));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'h0; req0_b = 16'h0; req1_a = 16'h0; req1_b = 16'h0;
        res_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        step(); step();
        reset = 1'b1;
        step();
    endtask

    // Counts edges until res_valid, bounded so the bench always terminates.
    task automatic wait_valid(input int max, output int lat);
        lat = 0;
        while (!res_valid && lat < max) begin
            step();
            lat++;
        end
    endtask

    // One complete transaction on a single requester; operands are scrambled right after accept.
    task automatic run_op(input string tag, input logic sel, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] z);
        int lat;
        if (sel) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        check({tag, " ready0"}, 64'(req0_ready), 64'(!sel));
        check({tag, " ready1"}, 64'(req1_ready), 64'(sel));
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'($urandom); req0_b = 16'($urandom);
        req1_a = 16'($urandom); req1_b = 16'($urandom);
        wait_valid(40, lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat(b)));
        check({tag, " res_z"}, 64'(res_z), 64'(z));
        check({tag, " res_id"}, 64'(res_id), 64'(sel));
        check({tag, " busy"}, 64'(busy), 64'(1));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, " valid drop"}, 64'(res_valid), 64'(0));
        check({tag, " busy drop"}, 64'(busy), 64'(0));
    endtask

    int          lat;
    int          bad;
    int          cyc;
    logic        m_pend, m_ptr, m_id, m_rv, g0, g1;
    int          m_due;
    logic [31:0] m_z;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        idle_inputs();

        vecs[0] = '{1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01};
        vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{1'b0, 16'h0000, 16'h1234, 32'h00000000};
        vecs[3] = '{1'b1, 16'h1234, 16'h0000, 32'h00000000};
        vecs[4] = '{1'b0, 16'h0001, 16'hFFFF, 32'h0000FFFF};
        vecs[5] = '{1'b1, 16'h8000, 16'h0002, 32'h00010000};
        vecs[6] = '{1'b0, 16'h1234, 16'h0010, 32'h00012340};
        vecs[7] = '{1'b1, 16'h00B3, 16'h0001, 32'h000000B3};
        vecs[8] = '{1'b0, 16'hFFFF, 16'h8000, 32'h7FFF8000};

        // Reset state, with a request pending to prove ready is held low.
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst res_valid", 64'(res_valid), 64'(0));
        check("rst res_z", 64'(res_z), 64'(0));
        check("rst res_id", 64'(res_id), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst ready0", 64'(req0_ready), 64'(0));
        check("rst ready1", 64'(req1_ready), 64'(0));
        do_reset();

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].z);
        end

        // Contention straight after reset: req0 first, then the pointer hands over to req1.
        do_reset();
        req0_valid = 1'b1; req0_a = 16'h00AA; req0_b = 16'h0080;
        req1_valid = 1'b1; req1_a = 16'h00B4; req1_b = 16'h00D0;
        #1;
        check("cont ready0", 64'(req0_ready), 64'(1));
        check("cont ready1", 64'(req1_ready), 64'(0));
        step();
        req0_a = 16'h1111; req0_b = 16'h2222;
        #1;
        check("cont busy ready0", 64'(req0_ready), 64'(0));
        check("cont busy ready1", 64'(req1_ready), 64'(0));
        wait_valid(40, lat);
        check("cont1 z", 64'(res_z), 64'(32'h00005500));
        check("cont1 id", 64'(res_id), 64'(0));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        req0_a = 16'h00AA; req0_b = 16'h0080;
        #1;
        check("cont2 ready0", 64'(req0_ready), 64'(0));
        check("cont2 ready1", 64'(req1_ready), 64'(1));
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_valid(40, lat);
        check("cont2 z", 64'(res_z), 64'(32'h00009240));
        check("cont2 id", 64'(res_id), 64'(1));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Backpressure: result must hold while the consumer stalls.
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        step();
        req0_valid = 1'b0;
        wait_valid(40, lat);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp z", 64'(res_z), 64'(32'hFFFE0001));
            check("bp valid", 64'(res_valid), 64'(1));
            check("bp busy", 64'(busy), 64'(1));
            check("bp readys", 64'({req0_ready, req1_ready}), 64'(0));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp release", 64'(res_valid), 64'(0));

        // Reset during CALC aborts the operation.
        req0_valid = 1'b1; req0_a = 16'h008E; req0_b = 16'h00E0;
        step();
        req0_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        reset = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("mid z", 64'(res_z), 64'(0));
        check("mid valid", 64'(res_valid), 64'(0));
        check("mid busy", 64'(busy), 64'(0));
        check("mid id", 64'(res_id), 64'(0));
        check("mid ready0", 64'(req0_ready), 64'(0));
        step();
        req0_valid = 1'b0;
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (res_valid || busy) bad++;
        end
        check("mid no result", 64'(bad), 64'(0));

        // Randomized run against the transaction-level model.
        do_reset();
        cyc = 0; m_pend = 1'b0; m_ptr = 1'b0; m_id = 1'b0; m_due = 0; m_z = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = rnd_op(); req0_b = rnd_op();
            req1_a = rnd_op(); req1_b = rnd_op();
            res_ready = ($urandom_range(0, 2) != 0);
            #1;
            g0   = !m_pend && req0_valid && (!req1_valid || !m_ptr);
            g1   = !m_pend && req1_valid && (!req0_valid || m_ptr);
            m_rv = m_pend && (cyc >= m_due);
            check("rnd ready0", 64'(req0_ready), 64'(g0));
            check("rnd ready1", 64'(req1_ready), 64'(g1));
            check("rnd valid", 64'(res_valid), 64'(m_rv));
            check("rnd busy", 64'(busy), 64'(m_pend));
            if (m_rv) begin
                check("rnd z", 64'(res_z), 64'(m_z));
                check("rnd id", 64'(res_id), 64'(m_id));
            end
            if (g0 || g1) begin
                m_pend = 1'b1;
                m_id   = g1;
                m_z    = g1 ? (32'(req1_a) * 32'(req1_b)) : (32'(req0_a) * 32'(req0_b));
                m_due  = cyc + 1 + exp_lat(g1 ? req1_b : req0_b);
            end else if (m_rv && res_ready) begin
                m_pend = 1'b0;
                m_ptr  = !m_id;
            end
            step();
            cyc++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_arb_ctrl.md
MULT_ARB_CTRL -- requirements
Module: mult_arb_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width; result width is 2*WIDTH.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req0_valid  input  1  requester 0 has operands pending.
REQ-005 Port: req0_ready  output  1  requester 0 operands accepted this cycle when high with req0_valid.
REQ-006 Port: req0_a, req0_b  input  WIDTH each  requester 0 unsigned operands.
REQ-007 Port: req1_valid  input  1  requester 1 has operands pending.
REQ-008 Port: req1_ready  output  1  requester 1 accept strobe.
REQ-009 Port: req1_a, req1_b  input  WIDTH each  requester 1 unsigned operands.
REQ-010 Port: res_valid  output  1  result available.
REQ-011 Port: res_ready  input  1  consumer takes result.
REQ-012 Port: res_z  output  2*WIDTH  unsigned product a*b.
REQ-013 Port: res_id  output  1  index of the requester that owns res_z.
REQ-014 Port: busy  output  1  high in CALC or DONE.

Function
REQ-015 FSM states IDLE, CALC, DONE; IDLE is the only state that accepts requests.
REQ-016 In IDLE, reqN_ready is combinational: high only for the granted requester, which is a requester with valid high, chosen by priority pointer on conflict; never both ready.
REQ-017 Priority pointer: round-robin; after each completed DONE->IDLE transfer it points to the requester other than res_id.
REQ-018 Accept (valid & ready at an edge): latch a, b, and id; clear accumulator and iteration counter; IDLE->CALC.
REQ-019 CALC, per cycle: if the current LSB of the shifted b register is 1, add the shifted a register to the 2*WIDTH accumulator; shift a left 1, shift b right 1, increment counter.
REQ-020 CALC->DONE after exactly WIDTH CALC cycles; res_valid rises WIDTH edges after the accepting edge.
REQ-021 DONE: res_valid=1; res_z and res_id are held stable while res_ready=0.
REQ-022 DONE with res_ready=1 at an edge: DONE->IDLE, res_valid drops; no new accept occurs on that same edge.
REQ-023 Operand inputs changing after the accepting edge have no effect on the in-flight result.
REQ-024 Accumulator never overflows: 0xFFFF*0xFFFF=0xFFFE0001; a=0 or b=0 gives res_z=0.
REQ-025 Requests arriving while busy wait; reqN_ready stays 0 until IDLE.

Reset
REQ-026 reset=0 forces immediately: state IDLE, res_valid=0, res_z=0, res_id=0, busy=0, both ready outputs 0 while asserted, pointer to requester 0.
REQ-027 Reset during CALC or DONE aborts the operation; no result is produced after release.

Configuration
REQ-028 Macro MULT_EARLY_TERM_EN: when defined, CALC exits to DONE after any CALC cycle in which the shifted b register becomes zero (latency = index of the most significant set bit of b + 1, minimum 1 cycle); when undefined, latency is always WIDTH; res_z is identical in both builds.

Verification
REQ-029 Single op: req0 a=0x00FF b=0x00FF -> res_z=0x0000FE01, res_id=0, res_valid 16 cycles after accept (macro undefined).
REQ-030 Contention: both valid in IDLE after reset, req0 a=0x00AA b=0x0080, req1 a=0x00B4 b=0x00D0 -> req0 served first (0x00005500), then req1 (0x00009240, res_id=1).
REQ-031 Backpressure: res_ready=0 for 5 cycles in DONE with a=0xFFFF b=0xFFFF -> res_z held 0xFFFE0001, busy=1, no ready asserted.
REQ-032 Reset mid-CALC: a=0x008E b=0x00E0, reset low 8 cycles after accept -> all outputs 0, no res_valid after release.
REQ-033 Early termination (macro defined): a=0x00B3 b=0x0001 -> res_z=0x000000B3 after 1 CALC cycle; b=0 -> res_z=0 after 1 cycle.
